pc_gen: RTL and testbench



---
 rtl/pc_gen.sv | 213 +++++++++++++++++++++
 tb/tb_pc_gen.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// -----------------------------------------------------------------------------
// pc_gen -- program counter / fetch-address generator for the RV32 core.
//
// Holds the architectural fetch PC. It steps by 4 when fetch accepts, and it
// applies trap, mret and branch/jump redirects by fixed priority. A
// BOOT/RUN/HALT state machine gates fetch. Misaligned branch targets are
// rejected and reported.
//
// Optional feature (macro PC_HISTORY_EN): a circular history of the new PC on
// every applied redirect. When the macro is undefined, no storage is built and
// the history outputs read as zero.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   fetch_ready        fetch accepts the current pc this cycle
//   branch_taken/target, trap/trap_vector, mret/mepc   redirect requests
//   halt_req, resume   enter / leave HALT
//   pc                 registered fetch PC
//   fetch_valid        pc is valid for fetch (RUN only)
//   halted             high while in HALT
//   misaligned_exc     one-cycle pulse on a rejected misaligned branch
//   misaligned_addr    last rejected target (held)
//   hist_rd_idx        history read index, 0 = newest
//   hist_rd_data       history entry at hist_rd_idx (combinational)
//   hist_count         valid history entries (saturating)
// -----------------------------------------------------------------------------
module pc_gen #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h8000_0000),
   parameter int              BOOT_CYCLES  = 2,
   parameter int              HIST_DEPTH   = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          fetch_ready,
   input  logic                          branch_taken,
   input  logic [XLEN-1:0]               branch_target,
   input  logic                          trap,
   input  logic [XLEN-1:0]               trap_vector,
   input  logic                          mret,
   input  logic [XLEN-1:0]               mepc,
   input  logic                          halt_req,
   input  logic                          resume,
   output logic [XLEN-1:0]               pc,
   output logic                          fetch_valid,
   output logic                          halted,
   output logic                          misaligned_exc,
   output logic [XLEN-1:0]               misaligned_addr,
   input  logic [$clog2(HIST_DEPTH)-1:0] hist_rd_idx,
   output logic [XLEN-1:0]               hist_rd_data,
   output logic [$clog2(HIST_DEPTH):0]   hist_count
);

   localparam int IDX_W = $clog2(HIST_DEPTH);
   localparam int CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   // Force a target onto a 4-byte boundary.
   function automatic logic [XLEN-1:0] align4(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

   // True when the address sits on a 4-byte boundary.
   function automatic logic is_aligned(input logic [XLEN-1:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

   state_t            state_r, state_s;
   logic [XLEN-1:0]   pc_r, pc_s;
   logic [CNT_W-1:0]  boot_cnt_r, boot_cnt_s;
   logic              fetch_valid_r;
   logic              halted_r;
   logic              exc_r, exc_s;
   logic [XLEN-1:0]   maddr_r, maddr_s;
   logic              rec_s;   // an applied redirect: pc_s is the new entry

   // Next-state, next-pc and exception decode.
   always_comb begin
      state_s    = state_r;
      pc_s       = pc_r;
      boot_cnt_s = boot_cnt_r;
      exc_s      = 1'b0;
      maddr_s    = maddr_r;
      rec_s      = 1'b0;
      case (state_r)
         ST_BOOT: begin
            // Requests are ignored during boot.
            if (boot_cnt_r == BOOT_LAST) begin
               state_s = ST_RUN;
            end else begin
               boot_cnt_s = boot_cnt_r + CNT_W'(1);
            end
         end
         ST_RUN: begin
            // halt_req does not block a redirect in the same cycle.
            if (halt_req) begin
               state_s = ST_HALT;
            end else begin
               state_s = ST_RUN;
            end
            if (trap) begin
               pc_s  = align4(trap_vector);
               rec_s = 1'b1;
            end else if (mret) begin
               pc_s  = align4(mepc);
               rec_s = 1'b1;
            end else if (branch_taken) begin
               if (is_aligned(branch_target)) begin
                  pc_s  = branch_target;
                  rec_s = 1'b1;
               end else begin
                  exc_s   = 1'b1;
                  maddr_s = branch_target;
               end
            end else if (fetch_ready) begin
               pc_s = pc_r + XLEN'(4);   // wraps modulo 2^XLEN
            end else begin
               pc_s = pc_r;
            end
         end
         ST_HALT: begin
            if (trap) begin
               pc_s    = align4(trap_vector);
               rec_s   = 1'b1;
               state_s = ST_RUN;
            end else if (resume) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_HALT;
            end
         end
         default: begin
            state_s = ST_BOOT;
         end
      endcase
   end

   // State, pc and registered output decodes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= ST_BOOT;
         pc_r          <= RESET_VECTOR;
         boot_cnt_r    <= '0;
         fetch_valid_r <= 1'b0;
         halted_r      <= 1'b0;
         exc_r         <= 1'b0;
         maddr_r       <= '0;
      end else begin
         state_r       <= state_s;
         pc_r          <= pc_s;
         boot_cnt_r    <= boot_cnt_s;
         fetch_valid_r <= (state_s == ST_RUN);
         halted_r      <= (state_s == ST_HALT);
         exc_r         <= exc_s;
         maddr_r       <= maddr_s;
      end
   end

   assign pc              = pc_r;
   assign fetch_valid     = fetch_valid_r;
   assign halted          = halted_r;
   assign misaligned_exc  = exc_r;
   assign misaligned_addr = maddr_r;

`ifdef PC_HISTORY_EN
   logic [XLEN-1:0]  hist_mem_r [HIST_DEPTH];
   logic [IDX_W-1:0] hist_wr_ptr_r;
   logic [IDX_W:0]   hist_count_r;
   logic [IDX_W-1:0] hist_rd_ptr_s;

   // History write pointer and saturating entry count.
   always_ff @(posedge clk) begin
      if (rst) begin
         hist_wr_ptr_r <= '0;
         hist_count_r  <= '0;
      end else if (rec_s) begin
         hist_wr_ptr_r <= hist_wr_ptr_r + IDX_W'(1);
         if (hist_count_r != (IDX_W+1)'(HIST_DEPTH)) begin
            hist_count_r <= hist_count_r + (IDX_W+1)'(1);
         end else begin
            hist_count_r <= hist_count_r;
         end
      end else begin
         hist_wr_ptr_r <= hist_wr_ptr_r;
         hist_count_r  <= hist_count_r;
      end
   end

   // History storage: the contents need no reset.
   always_ff @(posedge clk) begin
      if (rec_s) begin
         hist_mem_r[hist_wr_ptr_r] <= pc_s;
      end
   end

   // The newest entry sits one slot behind the write pointer.
   assign hist_rd_ptr_s = hist_wr_ptr_r - IDX_W'(1) - hist_rd_idx;
   assign hist_rd_data  = hist_mem_r[hist_rd_ptr_s];
   assign hist_count    = hist_count_r;
`else
   logic unused_hist_s;
   assign unused_hist_s = ^{hist_rd_idx, rec_s};
   assign hist_rd_data  = '0;
   assign hist_count    = '0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// -----------------------------------------------------------------------------
// tb_pc_gen -- self-checking bench for pc_gen (default parameters).
// Directed stimulus with literal expectations. A behavioural model is also
// compared against the DUT on every falling edge once the model is initialised.
// -----------------------------------------------------------------------------
module tb_pc_gen;
   localparam logic [31:0] RV = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_ready = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = 32'h0;
   logic        trap = 1'b0;
   logic [31:0] trap_vector = 32'h0;
   logic        mret = 1'b0;
   logic [31:0] mepc = 32'h0;
   logic        halt_req = 1'b0;
   logic        resume = 1'b0;
   logic [31:0] pc;
   logic        fetch_valid;
   logic        halted;
   logic        misaligned_exc;
   logic [31:0] misaligned_addr;
   logic [2:0]  hist_rd_idx = 3'd0;
   logic [31:0] hist_rd_data;
   logic [3:0]  hist_count;

   int checks = 0;
   int failures = 0;

   pc_gen dut (
      .clk(clk), .rst(rst), .fetch_ready(fetch_ready),
      .branch_taken(branch_taken), .branch_target(branch_target),
      .trap(trap), .trap_vector(trap_vector), .mret(mret), .mepc(mepc),
      .halt_req(halt_req), .resume(resume), .pc(pc),
      .fetch_valid(fetch_valid), .halted(halted),
      .misaligned_exc(misaligned_exc), .misaligned_addr(misaligned_addr),
      .hist_rd_idx(hist_rd_idx), .hist_rd_data(hist_rd_data),
      .hist_count(hist_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Modes: 0 = booting, 1 = running, 2 = halted.
   int          m_mode = 0;
   int          m_boot_left = 0;
   logic [31:0] m_pc = 32'h0;
   logic        m_exc = 1'b0;
   logic [31:0] m_maddr = 32'h0;
   logic [31:0] m_hist[$];
   bit          m_ok = 1'b0;

   function automatic void m_record(input logic [31:0] a);
      m_hist.push_front(a);
      if (m_hist.size() > 8) void'(m_hist.pop_back());
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_mode = 0; m_boot_left = 2; m_pc = RV; m_exc = 1'b0;
         m_maddr = 32'h0; m_hist.delete(); m_ok = 1'b1;
      end else if (m_ok) begin
         m_exc = 1'b0;
         if (m_mode == 0) begin
            m_boot_left--;
            if (m_boot_left == 0) m_mode = 1;
         end else if (m_mode == 1) begin
            if (trap) begin m_pc = trap_vector & ~32'h3; m_record(m_pc); end
            else if (mret) begin m_pc = mepc & ~32'h3; m_record(m_pc); end
            else if (branch_taken && (branch_target % 4 == 0)) begin
               m_pc = branch_target; m_record(m_pc);
            end
            else if (branch_taken) begin m_exc = 1'b1; m_maddr = branch_target; end
            else if (fetch_ready) m_pc = m_pc + 32'd4;
            if (halt_req) m_mode = 2;
         end else begin
            if (trap) begin m_pc = trap_vector & ~32'h3; m_record(m_pc); m_mode = 1; end
            else if (resume) m_mode = 1;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_ok) begin
         chk("m_pc", pc, m_pc);
         chk("m_fetch_valid", 32'(fetch_valid), 32'(m_mode == 1));
         chk("m_halted", 32'(halted), 32'(m_mode == 2));
         chk("m_exc", 32'(misaligned_exc), 32'(m_exc));
         chk("m_maddr", misaligned_addr, m_maddr);
`ifdef PC_HISTORY_EN
         chk("m_hist_count", 32'(hist_count), 32'(m_hist.size()));
         if (int'(hist_rd_idx) < m_hist.size())
            chk("m_hist_data", hist_rd_data, m_hist[int'(hist_rd_idx)]);
`else
         chk("m_hist_count", 32'(hist_count), 32'h0);
         chk("m_hist_data", hist_rd_data, 32'h0);
`endif
      end
   end

   // One clock: inputs already set; return 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      fetch_ready = 1'b0; branch_taken = 1'b0; trap = 1'b0;
      mret = 1'b0; halt_req = 1'b0; resume = 1'b0;
   endtask

   initial begin
      // Reset.
      rst = 1'b1; step(); step();
      chk("rst_pc", pc, RV);
      chk("rst_fv", 32'(fetch_valid), 32'h0);
      chk("rst_halted", 32'(halted), 32'h0);
      chk("rst_exc", 32'(misaligned_exc), 32'h0);
      chk("rst_maddr", misaligned_addr, 32'h0);
      chk("rst_hcount", 32'(hist_count), 32'h0);

      // Boot: a trap in boot is ignored.
      rst = 1'b0; fetch_ready = 1'b1; trap = 1'b1; trap_vector = 32'h0000_1230;
      step();
      chk("boot1_fv", 32'(fetch_valid), 32'h0);
      chk("boot1_pc", pc, RV);
      trap = 1'b0; step();
      chk("boot2_fv", 32'(fetch_valid), 32'h1);
      chk("boot2_pc", pc, RV);
      step(); chk("seq1", pc, 32'h8000_0004);
      step(); chk("seq2", pc, 32'h8000_0008);

      // Trap beats branch and fetch_ready; then mret.
      trap = 1'b1; trap_vector = 32'h8000_1003;
      branch_taken = 1'b1; branch_target = 32'h8000_0200;
      step(); chk("trap_pc", pc, 32'h8000_1000);
      clr(); mret = 1'b1; mepc = 32'h8000_0010;
      step(); chk("mret_pc", pc, 32'h8000_0010);

      // Misaligned branch, then an aligned one.
      clr(); branch_taken = 1'b1; branch_target = 32'h8000_0022;
      step();
      chk("mis_pc", pc, 32'h8000_0010);
      chk("mis_exc", 32'(misaligned_exc), 32'h1);
      chk("mis_addr", misaligned_addr, 32'h8000_0022);
      branch_target = 32'h8000_0040;
      step();
      chk("br_pc", pc, 32'h8000_0040);
      chk("br_exc", 32'(misaligned_exc), 32'h0);
      chk("br_addr_held", misaligned_addr, 32'h8000_0022);

      // Back-to-back misaligned pulses.
      branch_target = 32'h8000_0041; step();
      chk("b2b_exc1", 32'(misaligned_exc), 32'h1);
      branch_target = 32'h8000_0043; step();
      chk("b2b_exc2", 32'(misaligned_exc), 32'h1);
      chk("b2b_addr", misaligned_addr, 32'h8000_0043);
      clr(); step();
      chk("stall_exc", 32'(misaligned_exc), 32'h0);
      chk("stall_pc", pc, 32'h8000_0040);

      // Halt with a simultaneous branch.
      halt_req = 1'b1; branch_taken = 1'b1; branch_target = 32'h8000_0100;
      step();
      chk("halt_pc", pc, 32'h8000_0100);
      chk("halt_halted", 32'(halted), 32'h1);
      chk("halt_fv", 32'(fetch_valid), 32'h0);
      clr(); branch_taken = 1'b1; branch_target = 32'h8000_0300;
      mret = 1'b1; mepc = 32'h0000_0055; fetch_ready = 1'b1; halt_req = 1'b1;
      step(); chk("halt_frozen", pc, 32'h8000_0100);
      clr(); resume = 1'b1; step();
      chk("resume_fv", 32'(fetch_valid), 32'h1);
      chk("resume_halted", 32'(halted), 32'h0);
      chk("resume_pc", pc, 32'h8000_0100);
      clr(); fetch_ready = 1'b1; step();
      chk("resume_seq", pc, 32'h8000_0104);

      // Halt again, leave by trap.
      clr(); halt_req = 1'b1; step();
      chk("halt2", 32'(halted), 32'h1);
      clr(); trap = 1'b1; trap_vector = 32'h8000_2007; step();
      chk("halt_trap_pc", pc, 32'h8000_2004);
      chk("halt_trap_fv", 32'(fetch_valid), 32'h1);

      // Wrap-around.
      clr(); branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC; step();
      chk("wrap_pre", pc, 32'hFFFF_FFFC);
      clr(); fetch_ready = 1'b1; step();
      chk("wrap_pc", pc, 32'h0000_0000);

      // Reset while halted.
      clr(); halt_req = 1'b1; step();
      clr(); rst = 1'b1; trap = 1'b1; step();
      chk("rsth_pc", pc, RV);
      chk("rsth_halted", 32'(halted), 32'h0);
      chk("rsth_fv", 32'(fetch_valid), 32'h0);
      clr(); rst = 1'b0; step(); step();
      chk("rsth_run", 32'(fetch_valid), 32'h1);

      // Ten aligned redirects fill the history.
      for (int i = 1; i <= 10; i++) begin
         branch_taken = 1'b1; branch_target = 32'h1000 * i; step();
      end
      clr();
      hist_rd_idx = 3'd0; #1;
`ifdef PC_HISTORY_EN
      chk("hist_count", 32'(hist_count), 32'h8);
      chk("hist_idx0", hist_rd_data, 32'h0000_A000);
      hist_rd_idx = 3'd7; #1;
      chk("hist_idx7", hist_rd_data, 32'h0000_3000);
`else
      chk("hist_count", 32'(hist_count), 32'h0);
      chk("hist_idx0", hist_rd_data, 32'h0);
      hist_rd_idx = 3'd7; #1;
      chk("hist_idx7", hist_rd_data, 32'h0);
`endif
      step(); step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
